// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// dmem_arbiter: shares one LSU port between the core (priority) and a
// word-burst DMA/debug engine, with starvation relief and read-data routing.
// Revision: 1.0
// ============================================================================
module dmem_arbiter #(
  parameter int LEN_W      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_c_req,
  input  logic             i_c_wren,
  input  logic [31:0]      i_c_addr,
  input  logic [31:0]      i_c_wdata,
  input  logic [2:0]       i_c_funct3,
  output logic             o_c_gnt,
  output logic             o_c_rvalid,
  output logic [31:0]      o_c_rdata,
  input  logic             i_d_req,
  input  logic             i_d_wren,
  input  logic [31:0]      i_d_addr,
  input  logic [LEN_W-1:0] i_d_len,
  input  logic [31:0]      i_d_wdata,
  output logic             o_d_gnt,
  output logic             o_d_rvalid,
  output logic [31:0]      o_d_rdata,
  output logic             o_d_done,
  output logic [31:0]      o_lsu_addr,
  output logic [31:0]      o_lsu_wdata,
  output logic             o_lsu_wren,
  output logic [2:0]       o_lsu_funct3,
  input  logic [31:0]      i_lsu_rdata,
  output logic             o_busy
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] C_STARVE_MAX = SW'(STARVE_MAX);
  localparam logic [2:0]    C_FUNCT3_WORD = 3'b010;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_BURST = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [31:0]       addr_q, addr_d;
  logic              wren_q, wren_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              owner_q, owner_d;
  logic              load_q, load_d;
  logic              done_q, done_d;

  logic              d_win;
  logic              c_win;
  logic [LEN_W-1:0]  len_eff;
  logic [31:0]       beat_addr;
  logic              beat_wren;

  // Burst addresses wrap inside the current 64 KiB window.
  function automatic logic [31:0] next_word(input logic [31:0] a);
    return {a[31:16], a[15:0] + 16'd4};
  endfunction

  always_comb begin
    d_win     = !i_reset && i_d_req && (!i_c_req || starve_q == C_STARVE_MAX);
    c_win     = !i_reset && i_c_req && !d_win;
    len_eff   = (i_d_len == '0) ? LEN_W'(1) : i_d_len;
    beat_addr = (state_q == S_BURST) ? addr_q : i_d_addr;
    beat_wren = (state_q == S_BURST) ? wren_q : i_d_wren;

    state_d  = state_q;
    rem_d    = rem_q;
    addr_d   = addr_q;
    wren_d   = wren_q;
    starve_d = starve_q;
    done_d   = 1'b0;
    owner_d  = d_win;
    load_d   = (c_win && !i_c_wren) || (d_win && !beat_wren);

    if (d_win || !i_d_req) begin
      starve_d = '0;
    end else if (c_win && starve_q != C_STARVE_MAX) begin
      starve_d = starve_q + SW'(1);
    end

    if (d_win) begin
      addr_d = next_word(beat_addr);
      if (state_q == S_IDLE) begin
        wren_d = i_d_wren;
        rem_d  = len_eff - LEN_W'(1);
        if (len_eff == LEN_W'(1)) begin
          done_d = 1'b1;
        end else begin
          state_d = S_BURST;
        end
      end else begin
        rem_d = rem_q - LEN_W'(1);
        if (rem_q == LEN_W'(1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
    end

    o_lsu_addr   = '0;
    o_lsu_wdata  = '0;
    o_lsu_wren   = 1'b0;
    o_lsu_funct3 = C_FUNCT3_WORD;
    if (c_win) begin
      o_lsu_addr   = i_c_addr;
      o_lsu_wdata  = i_c_wdata;
      o_lsu_wren   = i_c_wren;
      o_lsu_funct3 = i_c_funct3;
    end else if (d_win) begin
      o_lsu_addr   = beat_addr;
      o_lsu_wdata  = i_d_wdata;
      o_lsu_wren   = beat_wren;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= S_IDLE;
      rem_q    <= '0;
      addr_q   <= '0;
      wren_q   <= 1'b0;
      starve_q <= '0;
      owner_q  <= 1'b0;
      load_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      addr_q   <= addr_d;
      wren_q   <= wren_d;
      starve_q <= starve_d;
      owner_q  <= owner_d;
      load_q   <= load_d;
      done_q   <= done_d;
    end
  end

  assign o_c_gnt    = c_win;
  assign o_d_gnt    = d_win;
  assign o_c_rvalid = load_q && !owner_q;
  assign o_d_rvalid = load_q && owner_q;
  assign o_c_rdata  = o_c_rvalid ? i_lsu_rdata : '0;
  assign o_d_rdata  = o_d_rvalid ? i_lsu_rdata : '0;
  assign o_d_done   = done_q;
  assign o_busy     = (state_q == S_BURST);

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_dmem_arbiter: directed and randomized checks of dmem_arbiter against a
// transaction-level model of bursts, starvation relief and read return.
// Revision: 1.0
// ============================================================================
module tb_dmem_arbiter;
  localparam int LEN_W      = 4;
  localparam int STARVE_MAX = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             c_req, c_wren;
  logic [31:0]      c_addr, c_wdata;
  logic [2:0]       c_funct3;
  logic             c_gnt, c_rvalid;
  logic [31:0]      c_rdata;
  logic             d_req, d_wren;
  logic [31:0]      d_addr, d_wdata;
  logic [LEN_W-1:0] d_len;
  logic             d_gnt, d_rvalid, d_done;
  logic [31:0]      d_rdata;
  logic [31:0]      lsu_addr, lsu_wdata, lsu_rdata;
  logic             lsu_wren, busy;
  logic [2:0]       lsu_funct3;

  dmem_arbiter #(.LEN_W(LEN_W), .STARVE_MAX(STARVE_MAX)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_c_req(c_req), .i_c_wren(c_wren), .i_c_addr(c_addr), .i_c_wdata(c_wdata),
    .i_c_funct3(c_funct3), .o_c_gnt(c_gnt), .o_c_rvalid(c_rvalid), .o_c_rdata(c_rdata),
    .i_d_req(d_req), .i_d_wren(d_wren), .i_d_addr(d_addr), .i_d_len(d_len),
    .i_d_wdata(d_wdata), .o_d_gnt(d_gnt), .o_d_rvalid(d_rvalid), .o_d_rdata(d_rdata),
    .o_d_done(d_done), .o_lsu_addr(lsu_addr), .o_lsu_wdata(lsu_wdata),
    .o_lsu_wren(lsu_wren), .o_lsu_funct3(lsu_funct3), .i_lsu_rdata(lsu_rdata),
    .o_busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: an open burst is described by beats still owed, next address, direction.
  bit          m_open;
  int          m_left;
  logic [31:0] m_next;
  bit          m_wr;
  int          m_starve;
  bit          m_c_rv, m_d_rv, m_done;

  // Snapshot of the last checked cycle, for hand-written expectations.
  bit          s_c_gnt, s_d_gnt, s_c_rv, s_d_rv, s_done, s_busy;
  logic [31:0] s_addr;
  logic [2:0]  s_f3;
  bit          s_wren;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] wrap4(input logic [31:0] a);
    logic [15:0] lo;
    lo = a[15:0] + 16'd4;
    return {a[31:16], lo};
  endfunction

  task automatic model_reset();
    m_open = 0; m_left = 0; m_next = '0; m_wr = 0; m_starve = 0;
    m_c_rv = 0; m_d_rv = 0; m_done = 0;
  endtask

  // Inputs are already set (at negedge); check this cycle, advance the model, move to next negedge.
  task automatic step();
    bit          eg_d, eg_c, e_wr;
    logic [31:0] e_addr, e_wdata;
    logic [2:0]  e_f3;
    int          n;
    #1;
    eg_d = !rst && d_req && (!c_req || m_starve == STARVE_MAX);
    eg_c = !rst && c_req && !eg_d;
    e_addr = '0; e_wdata = '0; e_wr = 0; e_f3 = 3'b010;
    if (eg_c) begin
      e_addr = c_addr; e_wdata = c_wdata; e_wr = c_wren; e_f3 = c_funct3;
    end else if (eg_d) begin
      e_addr = m_open ? m_next : d_addr; e_wdata = d_wdata; e_wr = m_open ? m_wr : d_wren;
    end
    chk("c_gnt", 32'(c_gnt), 32'(eg_c));
    chk("d_gnt", 32'(d_gnt), 32'(eg_d));
    chk("lsu_addr", lsu_addr, e_addr);
    chk("lsu_wdata", lsu_wdata, e_wdata);
    chk("lsu_wren", 32'(lsu_wren), 32'(e_wr));
    chk("lsu_funct3", 32'(lsu_funct3), 32'(e_f3));
    chk("busy", 32'(busy), 32'(m_open));
    chk("c_rvalid", 32'(c_rvalid), 32'(m_c_rv));
    chk("d_rvalid", 32'(d_rvalid), 32'(m_d_rv));
    chk("c_rdata", c_rdata, m_c_rv ? lsu_rdata : 32'h0);
    chk("d_rdata", d_rdata, m_d_rv ? lsu_rdata : 32'h0);
    chk("d_done", 32'(d_done), 32'(m_done));
    s_c_gnt = c_gnt; s_d_gnt = d_gnt; s_c_rv = c_rvalid; s_d_rv = d_rvalid;
    s_done = d_done; s_busy = busy; s_addr = lsu_addr; s_f3 = lsu_funct3; s_wren = lsu_wren;

    if (rst) begin
      model_reset();
    end else begin
      m_c_rv = eg_c && !c_wren;
      m_d_rv = eg_d && !e_wr;
      m_done = 0;
      if (eg_d) begin
        if (!m_open) begin
          n = (d_len == 0) ? 1 : int'(d_len);
          if (n == 1) m_done = 1;
          else begin
            m_open = 1; m_left = n - 1; m_next = wrap4(d_addr); m_wr = d_wren;
          end
        end else begin
          m_next = wrap4(m_next);
          m_left--;
          if (m_left == 0) begin
            m_open = 0; m_done = 1;
          end
        end
      end
      if (eg_d || !d_req) m_starve = 0;
      else if (eg_c && m_starve < STARVE_MAX) m_starve++;
    end
    @(posedge clk);
    @(negedge clk);
    lsu_rdata = $urandom;
    d_wdata   = $urandom;
    c_wdata   = $urandom;
  endtask

  initial begin
    logic [31:0] exp_burst [4];
    int          seen, cg_run;
    bit          got_done;

    rst = 1; c_req = 1; c_wren = 0; c_addr = '0; c_wdata = '0; c_funct3 = 3'b010;
    d_req = 1; d_wren = 0; d_addr = '0; d_len = '0; d_wdata = '0; lsu_rdata = '0;
    model_reset();
    @(posedge clk);
    @(negedge clk);

    // Reset held with both requests active
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_gnt", 32'(s_c_gnt | s_d_gnt), 32'h0);
      chk("rst_f3", 32'(s_f3), 32'h2);
    end

    // Core load only
    rst = 0; d_req = 0; c_req = 1; c_wren = 0; c_addr = 32'h10;
    step();
    chk("c_load_gnt", 32'(s_c_gnt), 32'h1);
    chk("c_load_addr", s_addr, 32'h10);
    c_req = 0;
    step();
    chk("c_load_rvalid", 32'(s_c_rv), 32'h1);

    // D write burst wrapping in the 64 KiB window
    exp_burst[0] = 32'h0000_FFF8; exp_burst[1] = 32'h0000_FFFC;
    exp_burst[2] = 32'h0000_0000; exp_burst[3] = 32'h0000_0004;
    d_req = 1; d_wren = 1; d_addr = 32'h0000_FFF8; d_len = 4'd4;
    seen = 0; got_done = 0;
    for (int i = 0; i < 12 && !got_done; i++) begin
      step();
      if (s_done) begin
        got_done = 1;
        chk("wburst_done_after", 32'(seen), 32'd4);
      end
      if (s_d_gnt) begin
        if (seen < 4) chk("wburst_addr", s_addr, exp_burst[seen]);
        seen++;
        if (seen == 4) d_req = 0;
      end
    end
    chk("wburst_done_seen", 32'(got_done), 32'h1);
    step();
    chk("wburst_busy_end", 32'(s_busy), 32'h0);

    // Starvation relief: core always requesting, D read burst of 2
    c_req = 1; c_wren = 0; d_req = 1; d_wren = 0; d_addr = 32'h100; d_len = 4'd2;
    seen = 0; cg_run = 0; got_done = 0;
    for (int i = 0; i < 30 && !got_done; i++) begin
      c_addr = $urandom;
      step();
      if (s_done) got_done = 1;
      if (s_c_gnt) cg_run++;
      if (s_d_gnt) begin
        chk("starve_run", 32'(cg_run), 32'd8);
        cg_run = 0;
        seen++;
        if (seen == 2) d_req = 0;
      end
    end
    chk("starve_done", 32'(got_done), 32'h1);
    c_req = 0;
    step();

    // Pause mid-burst then resume
    d_req = 1; d_wren = 0; d_addr = 32'h200; d_len = 4'd3;
    step();
    chk("pause_beat1", s_addr, 32'h200);
    d_req = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("pause_nogrant", 32'(s_d_gnt), 32'h0);
      chk("pause_busy", 32'(s_busy), 32'h1);
    end
    d_req = 1;
    step();
    chk("resume_beat2", s_addr, 32'h204);
    step();
    chk("resume_beat3", s_addr, 32'h208);
    d_req = 0;
    step();
    chk("resume_done", 32'(s_done), 32'h1);

    // Reset mid-burst drops it without a done pulse
    d_req = 1; d_addr = 32'h300; d_len = 4'd3;
    step();
    step();
    rst = 1;
    step();
    rst = 0; d_req = 0;
    step();
    chk("rstmid_done", 32'(s_done), 32'h0);
    chk("rstmid_busy", 32'(s_busy), 32'h0);

    // Simultaneous core load and single-beat D read
    c_req = 1; c_wren = 0; c_addr = 32'h40; d_req = 1; d_wren = 0; d_addr = 32'h80; d_len = 4'd1;
    step();
    chk("sim_c_first", 32'(s_c_gnt), 32'h1);
    c_req = 0;
    step();
    chk("sim_d_second", 32'(s_d_gnt), 32'h1);
    chk("sim_c_rv", 32'(s_c_rv), 32'h1);
    d_req = 0;
    step();
    chk("sim_d_rv", 32'(s_d_rv), 32'h1);
    chk("sim_done", 32'(s_done), 32'h1);

    // Randomized traffic with phases of heavy core load
    for (int i = 0; i < 4000; i++) begin
      rst      = ($urandom_range(0, 299) == 0);
      c_req    = (i % 800 < 400) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 1) == 1);
      c_wren   = $urandom_range(0, 1);
      c_addr   = $urandom;
      c_funct3 = 3'($urandom_range(0, 7));
      d_req    = m_open ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 2) == 0);
      d_wren   = $urandom_range(0, 1);
      d_addr   = {$urandom, 2'b00} >> 2 << 2;
      d_len    = LEN_W'($urandom_range(0, 15));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter in front of the load/store unit (data RAM plus MMIO).
- Shares the single LSU port between the core MEM stage (requester C, priority) and a word-burst DMA/debug engine (requester D).
- Sequences D bursts with address auto-increment and a beat counter.
- Returns read data to the owning requester, matching the LSU's 1-cycle synchronous read latency.

Parameters:
- LEN_W, 4, width of D burst length field (max burst 2^LEN_W-1 beats).
- STARVE_MAX, 8, consecutive C grants allowed while D is waiting before D is forced one beat.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  reset, synchronous, active-high.
- i_c_req  in  1  core access request, held until granted.
- i_c_wren  in  1  core store (1) / load (0).
- i_c_addr  in  32  core byte address.
- i_c_wdata  in  32  core store data.
- i_c_funct3  in  3  core access size/sign code (LSU encoding).
- o_c_gnt  out  1  core access issued to LSU this cycle.
- o_c_rvalid  out  1  core load data valid.
- o_c_rdata  out  32  core load data.
- i_d_req  in  1  D request; held for the whole burst.
- i_d_wren  in  1  D burst is write (1) / read (0); sampled on first beat.
- i_d_addr  in  32  D burst start address (word aligned); sampled on first beat.
- i_d_len  in  LEN_W  D beat count; 0 treated as 1; sampled on first beat.
- i_d_wdata  in  32  D write data for the current beat.
- o_d_gnt  out  1  D beat issued this cycle; D advances i_d_wdata.
- o_d_rvalid  out  1  D read beat data valid.
- o_d_rdata  out  32  D read data.
- o_d_done  out  1  one-cycle pulse: burst complete.
- o_lsu_addr  out  32  to LSU address.
- o_lsu_wdata  out  32  to LSU store data.
- o_lsu_wren  out  1  to LSU write enable.
- o_lsu_funct3  out  3  to LSU funct3.
- i_lsu_rdata  in  32  from LSU load data, valid 1 cycle after issue.
- o_busy  out  1  D burst in progress.

Behaviour:
- Reset (synchronous, i_reset=1 at posedge):
  - state=IDLE; beat counter, starve counter and owner/read flags cleared.
  - o_d_done=0; o_c_rvalid=o_d_rvalid=0 from the next cycle; o_busy=0.
  - A burst in flight is dropped silently, with no done pulse.
- States:
  - IDLE: no D burst active.
  - BURST: D burst latched; beats remaining > 0.
- Per-cycle grant, combinational, at most one of o_c_gnt/o_d_gnt:
  - D eligible = i_d_req (in IDLE or BURST).
  - Default: C wins if i_c_req.
  - D wins if D eligible and (!i_c_req or starve==STARVE_MAX).
- Starve counter:
  - +1 on each cycle C is granted while D is eligible.
  - Cleared on a D grant or when i_d_req=0.
  - Saturates at STARVE_MAX.
- IDLE -> BURST on the first D grant:
  - Latch wren, len (0->1) minus 1 into remaining, and addr+4 into next address.
  - First beat uses i_d_addr directly.
  - If len<=1, stay IDLE and pulse done.
- BURST:
  - Each D grant issues next address and decrements remaining.
  - Address increment: next address +4, low 16 bits wrap mod 64 KiB, bits[31:16] held.
  - Grant with remaining==1 -> IDLE.
  - i_d_req=0 mid-burst pauses: no beats, state and counters held.
- LSU drive:
  - On C grant: C fields pass straight through.
  - On D grant: burst/first-beat address, i_d_wdata, wren, funct3=3'b010.
  - No grant: addr=0, wdata=0, wren=0, funct3=3'b010.
  - All combinational, sampled by the LSU at the next posedge.
- Read return:
  - Registered owner bit and "was load" flag.
  - In the cycle after a load grant, the owner's rvalid=1 and its rdata=i_lsu_rdata; the other requester's rdata=0.
  - Stores produce no rvalid.
- o_d_done:
  - Registered; asserted the cycle after the final beat grant, coincident with the final o_d_rvalid for reads.
- o_busy = (state==BURST).
- No hazard detection between C and D accesses; ordering equals grant order.
- Back-to-back grants every cycle are allowed; throughput is 1 access/cycle.

Test Plan:
- Reset: hold i_reset=1 two cycles with both requests high -> all gnt/rvalid/done=0, o_lsu_wren=0, o_lsu_funct3=010, o_busy=0.
- C only: load 0x0000_0010 -> o_c_gnt same cycle; o_c_rvalid next cycle with o_c_rdata=i_lsu_rdata.
- D write burst, len=4, addr 0x0000_FFF8, C idle -> o_lsu_addr sequence FFF8, FFFC, 0000, 0004; o_d_done pulses the cycle after the 4th o_d_gnt; o_busy then 0.
- Starvation: C requests continuously, D burst len=2 -> C granted 8 cycles, then D beat; repeat; done after 2 D beats.
- Pause/reset: D read len=3, drop i_d_req after beat 1 for 3 cycles -> no beats, o_busy=1; resume -> beats at +4, +8; assert i_reset mid-burst in a rerun -> IDLE, no o_d_done.
- Simultaneous C load and D read start, starve=0 -> C granted; D granted next cycle; rvalids route to the correct owners on consecutive cycles.
